streammux: RTL and testbench



---
 rtl/streammux.sv | 106 ++++++++++
 tb/tb_streammux.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/streammux.sv
// Round-robin N-channel valid/ready stream merger with optional packet lock; output registered, 1-cycle latency.
// Backpressure: i_ready reaches o_ready combinationally through advance; no skid buffer, so a stalled output stalls every input.
module streammux #(
  parameter int W            = 32,
  parameter int NCH          = 4,
  parameter int OPT_PACKET   = 1,
  parameter int OPT_LOWPOWER = 0,
  localparam int CW          = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [NCH-1:0]   i_valid,
  output logic [NCH-1:0]   o_ready,
  input  logic [NCH*W-1:0] i_data,
  input  logic [NCH-1:0]   i_last,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [W-1:0]     o_data,
  output logic             o_last,
  output logic [CW-1:0]    o_chan
);

  logic [CW-1:0] r_grant;
  logic          r_locked;
  logic          r_valid;
  logic [W-1:0]  r_data;
  logic          r_last;
  logic [CW-1:0] r_chan;

  logic          w_advance;
  logic          w_any;
  logic          w_found;
  logic [CW-1:0] w_sel;
  logic [W-1:0]  w_data;
  logic          w_last;

  assign w_advance = !r_valid || i_ready;

  // Scan starts one past the last-served channel, so the previous winner ranks lowest.
  always_comb begin
    logic [CW-1:0] idx;
    idx     = '0;
    w_sel   = r_grant;
    w_found = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      idx = CW'((int'(r_grant) + i) % NCH);
      if (!w_found && i_valid[idx]) begin
        w_sel   = idx;
        w_found = 1'b1;
      end
    end
    if (r_locked) begin
      w_sel = r_grant;
    end
  end

  assign w_any = r_locked ? i_valid[r_grant] : |i_valid;

  always_comb begin
    o_ready = '0;
    w_data  = '0;
    w_last  = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (w_sel == CW'(k)) begin
        w_data     = i_data[k*W +: W];
        w_last     = i_last[k];
        o_ready[k] = w_advance && w_any;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_grant  <= CW'(NCH - 1);
      r_locked <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_last   <= 1'b0;
      r_chan   <= '0;
    end else if (w_advance) begin
      if (w_any) begin
        r_valid <= 1'b1;
        r_data  <= w_data;
        r_chan  <= w_sel;
        r_grant <= w_sel;
        r_last  <= (OPT_PACKET != 0) ? w_last : 1'b1;
        if (OPT_PACKET != 0) begin
          r_locked <= !w_last;
        end
      end else begin
        r_valid <= 1'b0;
        if (OPT_LOWPOWER != 0) begin
          r_data <= '0;
          r_last <= 1'b0;
          r_chan <= '0;
        end
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;
  assign o_chan  = r_chan;

endmodule

// File: tb/tb_streammux.sv
// Drives a packet/low-power instance and a per-beat instance with shared stimulus, checked against a reference model.
module tb_streammux;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   iv  = '0;
  logic [3:0]   il  = '0;
  logic [127:0] id  = '0;
  logic         ir  = 1'b0;

  logic [3:0]  a_rdy, b_rdy;
  logic        a_v, b_v, a_l, b_l;
  logic [31:0] a_d, b_d;
  logic [1:0]  a_c, b_c;

  int checks = 0;
  int errors = 0;

  // Reference state; index 0 = packet+lowpower instance, 1 = per-beat instance
  int          m_grant[2];
  bit          m_locked[2];
  bit          m_v[2];
  bit          m_l[2];
  logic [31:0] m_d[2];
  int          m_c[2];

  always #5 clk = ~clk;

  streammux #(.W(32), .NCH(4), .OPT_PACKET(1), .OPT_LOWPOWER(1)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_valid(iv), .o_ready(a_rdy), .i_data(id), .i_last(il),
    .o_valid(a_v), .i_ready(ir), .o_data(a_d), .o_last(a_l), .o_chan(a_c)
  );

  streammux #(.W(32), .NCH(4), .OPT_PACKET(0), .OPT_LOWPOWER(0)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_valid(iv), .o_ready(b_rdy), .i_data(id), .i_last(il),
    .o_valid(b_v), .i_ready(ir), .o_data(b_d), .o_last(b_l), .o_chan(b_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    for (int m = 0; m < 2; m++) begin
      m_grant[m] = 3; m_locked[m] = 0; m_v[m] = 0; m_l[m] = 0; m_d[m] = '0; m_c[m] = 0;
    end
  endtask

  // Winner = first requester after the last-served channel, or the locked channel.
  function automatic void msel(input int m, output int sel, output bit any);
    sel = m_grant[m];
    any = 0;
    if (m_locked[m]) begin
      any = iv[m_grant[m]];
    end else begin
      for (int i = 1; i <= 4; i++) begin
        int k;
        k = (m_grant[m] + i) % 4;
        if (!any && iv[k]) begin
          sel = k;
          any = 1;
        end
      end
    end
  endfunction

  function automatic logic [3:0] mready(input int m);
    int sel;
    bit any;
    msel(m, sel, any);
    return ((!m_v[m] || ir) && any) ? 4'(1 << sel) : 4'd0;
  endfunction

  task automatic pre();
    #1;
    chk("a_ready", 32'(a_rdy), 32'(mready(0)));
    chk("b_ready", 32'(b_rdy), 32'(mready(1)));
  endtask

  task automatic post();
    int sel;
    bit any;
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      msel(m, sel, any);
      if (!m_v[m] || ir) begin
        if (any) begin
          m_v[m] = 1; m_d[m] = id[sel*32 +: 32]; m_c[m] = sel; m_grant[m] = sel;
          m_l[m] = (m == 0) ? il[sel] : 1'b1;
          if (m == 0) m_locked[m] = !il[sel];
        end else begin
          m_v[m] = 0;
          if (m == 0) begin m_d[m] = '0; m_l[m] = 0; m_c[m] = 0; end
        end
      end
    end
    @(negedge clk);
    chk("a_valid", 32'(a_v), 32'(m_v[0]));
    chk("a_data",  a_d,      m_d[0]);
    chk("a_last",  32'(a_l), 32'(m_l[0]));
    chk("a_chan",  32'(a_c), 32'(m_c[0]));
    chk("b_valid", 32'(b_v), 32'(m_v[1]));
    chk("b_data",  b_d,      m_d[1]);
    chk("b_last",  32'(b_l), 32'(m_l[1]));
    chk("b_chan",  32'(b_c), 32'(m_c[1]));
  endtask

  task automatic tick();
    pre();
    post();
  endtask

  initial begin
    // Reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_a_valid", 32'(a_v), 32'd0);
    chk("rst_a_data",  a_d,      32'd0);
    chk("rst_a_last",  32'(a_l), 32'd0);
    chk("rst_a_chan",  32'(a_c), 32'd0);
    chk("rst_b_valid", 32'(b_v), 32'd0);
    mreset();
    @(negedge clk);
    rst = 1'b0;

    // All channels valid: strict rotation 0,1,2,3,0 starting from channel 0
    iv = 4'hF; il = 4'hF; ir = 1'b1;
    id = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("rr_a_chan",  32'(a_c), 32'(j % 4));
      chk("rr_a_data",  a_d,      32'hA0 + 32'(j % 4));
      chk("rr_a_valid", 32'(a_v), 32'd1);
      chk("rr_b_chan",  32'(b_c), 32'(j % 4));
    end

    // Three-beat packet on ch2; ch0/ch1 must not interleave
    iv = 4'b0100; il = 4'b0000; id[64 +: 32] = 32'hC0;
    tick();
    chk("pkt1_chan", 32'(a_c), 32'd2);
    chk("pkt1_last", 32'(a_l), 32'd0);
    iv = 4'b0111; il = 4'b0011; id[64 +: 32] = 32'hC1;
    pre();
    chk("pkt2_ready", 32'(a_rdy), 32'b0100);
    post();
    chk("pkt2_chan", 32'(a_c), 32'd2);
    chk("pkt2_last", 32'(a_l), 32'd0);
    il = 4'b0111; id[64 +: 32] = 32'hC2;
    tick();
    chk("pkt3_chan", 32'(a_c), 32'd2);
    chk("pkt3_last", 32'(a_l), 32'd1);
    chk("pkt3_data", a_d,      32'hC2);
    iv = 4'b0011;
    tick();
    chk("pkt4_chan", 32'(a_c), 32'd0);
    chk("pkt4_last", 32'(a_l), 32'd1);

    // Backpressure: output holds 0x55 for 5 stalled cycles
    iv = 4'b0010; il = 4'hF; id[32 +: 32] = 32'h55; id[96 +: 32] = 32'h33;
    tick();
    chk("bp_data0", a_d, 32'h55);
    ir = 1'b0; iv = 4'b1010;
    for (int j = 0; j < 5; j++) begin
      pre();
      chk("bp_ready", 32'(a_rdy), 32'd0);
      post();
      chk("bp_data",  a_d,      32'h55);
      chk("bp_chan",  32'(a_c), 32'd1);
      chk("bp_valid", 32'(a_v), 32'd1);
    end
    ir = 1'b1; iv = 4'b1000;
    pre();
    chk("bp_release_ready", 32'(a_rdy), 32'b1000);
    post();
    chk("bp_next_chan", 32'(a_c), 32'd3);
    chk("bp_next_data", a_d,      32'h33);

    // Locked channel stalls: ch1 opens a packet then goes quiet while ch3 waits
    iv = 4'b1010; il = 4'b1000; id[32 +: 32] = 32'h61;
    tick();
    chk("lk_chan", 32'(a_c), 32'd1);
    chk("lk_last", 32'(a_l), 32'd0);
    iv = 4'b1000;
    for (int j = 0; j < 3; j++) begin
      pre();
      chk("lk_stall_ready", 32'(a_rdy), 32'd0);
      post();
      chk("lk_stall_valid", 32'(a_v), 32'd0);
    end
    iv = 4'b1010; il = 4'b1010; id[32 +: 32] = 32'h62;
    pre();
    chk("lk_resume_ready", 32'(a_rdy), 32'b0010);
    post();
    chk("lk_end_chan", 32'(a_c), 32'd1);
    chk("lk_end_last", 32'(a_l), 32'd1);
    chk("lk_end_data", a_d,      32'h62);
    iv = 4'b1000;
    pre();
    chk("lk_free_ready", 32'(a_rdy), 32'b1000);
    post();
    chk("lk_free_chan", 32'(a_c), 32'd3);

    // Idle after drain: low-power instance zeroes its payload
    iv = 4'b0000;
    tick();
    chk("lp_valid", 32'(a_v), 32'd0);
    chk("lp_data",  a_d,      32'd0);
    chk("lp_last",  32'(a_l), 32'd0);
    chk("lp_chan",  32'(a_c), 32'd0);

    // Reset while locked with a beat in the output register
    iv = 4'b0100; il = 4'b0000;
    tick();
    chk("mr_pre_valid", 32'(a_v), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mr_a_valid", 32'(a_v), 32'd0);
    chk("mr_b_valid", 32'(b_v), 32'd0);
    mreset();
    @(negedge clk);
    rst = 1'b0;
    iv = 4'b1010; il = 4'hF;
    tick();
    chk("mr_first_chan", 32'(a_c), 32'd1);

    // Randomized traffic against the reference model
    for (int j = 0; j < 600; j++) begin
      iv = 4'($urandom);
      il = 4'($urandom);
      id = {$urandom(), $urandom(), $urandom(), $urandom()};
      ir = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
